// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver/transmitter types and default constants
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - parallel byte output bus of the UART receiver
interface uart_rx_if #(
    parameter int DATA_BITS = uart_pkg::UART_DATA_BITS
);
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 framing_error;
    logic                 overrun_error;

    // The receiver drives the byte and status; the consumer drives data_ready.
    modport master (
        output data_out,
        output data_valid,
        output framing_error,
        output overrun_error,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  framing_error,
        input  overrun_error,
        output data_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - clk divider producing one oversample tick every CLKS_PER_SAMPLE cycles
module uart_baud_tick #(
    parameter int CLKS_PER_SAMPLE = 27
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    output logic tick_o
);
    import uart_pkg::*;

    localparam int             CW      = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_SAMPLE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Wrap at CNT_MAX; clear holds the phase at zero so the first tick lands
    // CLKS_PER_SAMPLE cycles after the clear is released.
    always_comb begin
        count_d = count_q;
        if (clear_i || (count_q == CNT_MAX)) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = !clear_i && (count_q == CNT_MAX);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with valid/ready holding register
module uart_rx #(
    parameter int DATA_BITS       = uart_pkg::UART_DATA_BITS,
    parameter int OVERSAMPLE      = uart_pkg::UART_OVERSAMPLE,
    parameter int CLKS_PER_SAMPLE = 27
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        rx_in,
    output logic        busy,
    uart_rx_if.master   rx_bus
);
    import uart_pkg::*;

    localparam int            SW        = $clog2(OVERSAMPLE);
    localparam int            BW        = $clog2(DATA_BITS);
    localparam logic [SW-1:0] SAMP_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_meta_q;
    logic                 rx_s_q;
    rx_state_t            state_q,        state_d;
    logic [SW-1:0]        samp_cnt_q,     samp_cnt_d;
    logic [BW-1:0]        bit_idx_q,      bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q,        shreg_d;
    logic [DATA_BITS-1:0] data_out_q,     data_out_d;
    logic                 data_valid_q,   data_valid_d;
    logic                 framing_err_q,  framing_err_d;
    logic                 overrun_err_q,  overrun_err_d;
    logic                 tick;

    // The tick phase restarts on every start edge because IDLE holds it clear.
    uart_baud_tick #(
        .CLKS_PER_SAMPLE (CLKS_PER_SAMPLE)
    ) u_baud_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (state_q == IDLE),
        .tick_o  (tick)
    );

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state: frame FSM, shift register, holding register and error pulses.
    always_comb begin
        state_d       = state_q;
        samp_cnt_d    = samp_cnt_q;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        framing_err_d = 1'b0;
        overrun_err_d = 1'b0;

        // Consumer drain; a byte loading in the same cycle overrides it below.
        if (data_valid_q && rx_bus.data_ready) begin
            data_valid_d = 1'b0;
        end

        if (!enable) begin
            state_d    = IDLE;
            samp_cnt_d = '0;
            bit_idx_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    samp_cnt_d = '0;
                    bit_idx_d  = '0;
                    if (!rx_s_q) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (samp_cnt_q == SAMP_HALF) begin
                            samp_cnt_d = '0;
                            bit_idx_d  = '0;
                            // A line that is high again at mid start bit was a glitch.
                            state_d    = rx_s_q ? IDLE : DATA;
                        end else begin
                            samp_cnt_d = samp_cnt_q + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (samp_cnt_q == SAMP_LAST) begin
                            samp_cnt_d = '0;
                            shreg_d    = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                            if (bit_idx_q == BIT_LAST) begin
                                state_d = STOP;
                            end else begin
                                bit_idx_d = bit_idx_q + BW'(1);
                            end
                        end else begin
                            samp_cnt_d = samp_cnt_q + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (samp_cnt_q == SAMP_LAST) begin
                            samp_cnt_d = '0;
                            state_d    = IDLE;
                            if (!rx_s_q) begin
                                framing_err_d = 1'b1;
                            end else if (!data_valid_q || rx_bus.data_ready) begin
                                data_out_d   = shreg_q;
                                data_valid_d = 1'b1;
                            end else begin
                                overrun_err_d = 1'b1;
                            end
                        end else begin
                            samp_cnt_d = samp_cnt_q + SW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            samp_cnt_q    <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            samp_cnt_q    <= samp_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            framing_err_q <= framing_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign busy                 = (state_q != IDLE);
    assign rx_bus.data_out      = data_out_q;
    assign rx_bus.data_valid    = data_valid_q;
    assign rx_bus.framing_error = framing_err_q;
    assign rx_bus.overrun_error = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int CPS      = 4;
    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int BIT_CLKS = CPS * OS;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic rx_in;
    logic busy;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(
        .DATA_BITS       (DB),
        .OVERSAMPLE      (OS),
        .CLKS_PER_SAMPLE (CPS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .rx_in   (rx_in),
        .busy    (busy),
        .rx_bus  (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Output monitor, sampled on the falling edge.
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         vcyc   = 0;
    logic [7:0] beats[$];

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.framing_error) fe_cnt++;
            if (bus.overrun_error) ov_cnt++;
            if (bus.data_valid) vcyc++;
            if (bus.data_valid && bus.data_ready) beats.push_back(bus.data_out);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One frame LSB-first; a 0 stop bit is held low just past mid-bit then released.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_in = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            step(BIT_CLKS);
        end
        if (stop) begin
            rx_in = 1'b1;
            step(BIT_CLKS);
        end else begin
            rx_in = 1'b0;
            step(40);
            rx_in = 1'b1;
            step(BIT_CLKS - 40);
        end
        rx_in = 1'b1;
    endtask

    task automatic pulse_ready();
        bus.data_ready = 1'b1;
        step(1);
        bus.data_ready = 1'b0;
    endtask

    int         vcyc_base;
    logic [7:0] part;

    initial begin
        reset_n        = 1'b0;
        enable         = 1'b1;
        rx_in          = 1'b1;
        bus.data_ready = 1'b0;
        step(5);

        check("rst_data_out",   32'(bus.data_out),      32'h0);
        check("rst_data_valid", 32'(bus.data_valid),    32'h0);
        check("rst_fe",         32'(bus.framing_error), 32'h0);
        check("rst_ov",         32'(bus.overrun_error), 32'h0);
        check("rst_busy",       32'(busy),              32'h0);

        reset_n = 1'b1;
        step(10);
        check("idle_busy", 32'(busy), 32'h0);

        // Frame 0x55 held with ready low, then drained.
        send_frame(8'h55, 1'b1);
        check("f55_valid", 32'(bus.data_valid), 32'h1);
        check("f55_data",  32'(bus.data_out),   32'h55);
        check("f55_busy",  32'(busy),           32'h0);
        step(100);
        check("f55_hold_valid", 32'(bus.data_valid), 32'h1);
        check("f55_hold_data",  32'(bus.data_out),   32'h55);
        pulse_ready();
        check("f55_drained", 32'(bus.data_valid), 32'h0);
        check("f55_beats",   32'(beats.size()),   32'd1);
        check("f55_beat0",   32'(beats[0]),       32'h55);

        // Short low glitch: start bit rejected at mid-start sample.
        rx_in = 1'b0;
        step(20);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        rx_in = 1'b1;
        step(60);
        check("glitch_busy_lo", 32'(busy),           32'h0);
        check("glitch_valid",   32'(bus.data_valid), 32'h0);
        check("glitch_fe",      32'(fe_cnt),         32'd0);
        check("glitch_ov",      32'(ov_cnt),         32'd0);

        // Frame 0xA3 with a 0 stop bit: one framing pulse, nothing stored.
        send_frame(8'hA3, 1'b0);
        step(40);
        check("fe_count", 32'(fe_cnt),         32'd1);
        check("fe_valid", 32'(bus.data_valid), 32'h0);
        check("fe_ov",    32'(ov_cnt),         32'd0);
        check("fe_busy",  32'(busy),           32'h0);

        // Frames 0x11, 0x22 with ready low: second one overruns.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        step(10);
        check("ov_valid", 32'(bus.data_valid), 32'h1);
        check("ov_data",  32'(bus.data_out),   32'h11);
        check("ov_count", 32'(ov_cnt),         32'd1);
        check("ov_fe",    32'(fe_cnt),         32'd1);
        pulse_ready();
        check("ov_drained", 32'(bus.data_valid), 32'h0);
        check("ov_beat",    32'(beats[1]),       32'h11);

        // Back-to-back 0x3C, 0xC3 with ready high: one-cycle beats each.
        vcyc_base      = vcyc;
        bus.data_ready = 1'b1;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        step(10);
        bus.data_ready = 1'b0;
        check("b2b_beats",  32'(beats.size()),    32'd4);
        check("b2b_beat2",  32'(beats[2]),        32'h3C);
        check("b2b_beat3",  32'(beats[3]),        32'hC3);
        check("b2b_vcyc",   32'(vcyc - vcyc_base), 32'd2);
        check("b2b_errors", 32'(fe_cnt + ov_cnt),  32'd2);
        check("b2b_valid",  32'(bus.data_valid),  32'h0);

        // Enable dropped mid-frame: back to idle, no flags.
        rx_in = 1'b0;
        step(100);
        check("en_busy_hi", 32'(busy), 32'h1);
        enable = 1'b0;
        step(1);
        check("en_busy_lo", 32'(busy), 32'h0);
        rx_in = 1'b1;
        step(20);
        enable = 1'b1;
        step(700);
        check("en_fe",    32'(fe_cnt),         32'd1);
        check("en_ov",    32'(ov_cnt),         32'd1);
        check("en_valid", 32'(bus.data_valid), 32'h0);

        // Reset during bit 4 of a frame, with a byte pending, then a clean 0x7E.
        send_frame(8'h99, 1'b1);
        check("pre_rst_data", 32'(bus.data_out), 32'h99);
        part  = 8'h5A;
        rx_in = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx_in = part[i];
            step(BIT_CLKS);
        end
        rx_in = part[4];
        step(BIT_CLKS / 2);
        reset_n = 1'b0;
        #2;
        check("mid_rst_data",  32'(bus.data_out),   32'h0);
        check("mid_rst_valid", 32'(bus.data_valid), 32'h0);
        check("mid_rst_busy",  32'(busy),           32'h0);
        rx_in = 1'b1;
        step(5);
        reset_n = 1'b1;
        step(20);
        send_frame(8'h7E, 1'b1);
        check("post_rst_valid", 32'(bus.data_valid), 32'h1);
        check("post_rst_data",  32'(bus.data_out),   32'h7E);
        check("post_rst_fe",    32'(fe_cnt),         32'd1);
        check("post_rst_ov",    32'(ov_cnt),         32'd1);
        pulse_ready();
        check("post_rst_drained", 32'(bus.data_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver that converts the asynchronous serial line into parallel bytes.
- It samples the line mid-bit and shifts bits in LSB-first.
- It checks the stop bit, then presents each byte on a valid/ready output holding register.
- It sits between the pad and the parallel consumer (host FIFO / register bank), mirroring the transmit-side shift path.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, sample ticks per bit period (even, >=4).
- CLKS_PER_SAMPLE, 27, clk cycles per sample tick (>=1); 27 suits 50 MHz/115200.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous reset, active-low
- enable  input  1  receiver enable; low aborts any frame and holds FSM in IDLE
- rx_in  input  1  raw serial line, idle high, asynchronous to clk
- data_out  output  DATA_BITS  received byte, valid while data_valid=1
- data_valid  output  1  holding register full
- data_ready  input  1  consumer accepts data_out when data_valid=1
- framing_error  output  1  one-cycle pulse: stop bit sampled 0
- overrun_error  output  1  one-cycle pulse: frame completed while holding register full and not being drained
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, reset_n=0): data_out=0, data_valid=0, framing_error=0, overrun_error=0, busy=0. FSM=IDLE, counters=0, both synchronizer flops=1.
- Synchronizer: two flops on rx_in; rx_s is the second stage. All decisions use rx_s only.
- Tick generator: counts 0..CLKS_PER_SAMPLE-1 and pulses tick when count = max. It is held at 0 in IDLE, so phase is aligned to start-edge detection.
- Sample counter: 0..OVERSAMPLE-1, advances on tick.
- FSM transitions:
  - IDLE: if enable && rx_s==0, go to START; clear tick and sample counters.
  - START: on the tick that completes OVERSAMPLE/2 ticks (mid start bit), sample rx_s. If 0, go to DATA with counters cleared and bit index 0. If 1, treat as a glitch and return to IDLE with no flags.
  - DATA: every OVERSAMPLE ticks (mid-bit), shift right: shreg <= {rx_s, shreg[DATA_BITS-1:1]}, so the first bit received ends in bit 0. After DATA_BITS samples, go to STOP.
  - STOP: after OVERSAMPLE ticks (mid stop bit), sample rx_s and return to IDLE in the same cycle. The next start edge can be detected from the following cycle.
- Frame completion at the mid-stop sample cycle; effects visible the next cycle:
  - rx_s==1 and (data_valid==0 or data_ready==1): data_out <= shreg, data_valid <= 1.
  - rx_s==1, data_valid==1 and data_ready==0: overrun_error pulses; the new byte is dropped and data_out/data_valid are unchanged.
  - rx_s==0: framing_error pulses; the byte is discarded and the holding register is untouched.
- Handshake: data_valid clears the cycle after data_valid && data_ready, unless a new byte loads in that same cycle, in which case it stays 1. data_out is stable while data_valid=1.
- Latency: from the first rx_s==0 cycle, the mid-stop sample occurs after (OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE) ticks. Two further cycles of synchronizer delay precede this.
- enable deasserted mid-frame: the FSM goes to IDLE next cycle with no error flags. The holding register and data_valid are retained, and the handshake keeps working.
- Line held low (break): produces a framing_error, then an immediate new START. No special break detection.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is lost.

Decomposition:
- uart_pkg: rx_state_t enum {IDLE, START, DATA, STOP} and default constants UART_OVERSAMPLE=16, UART_DATA_BITS=8. These are shared with the transmitter.
- One sub-module, uart_baud_tick: CLKS_PER_SAMPLE divider with a clear input and a tick output.
- The FSM, shift register and holding register stay in uart_rx.

Test Plan (CLKS_PER_SAMPLE=4, OVERSAMPLE=16, so bit period = 64 clk):
- Frame 0x55 (start 0, bits 1,0,1,0…, stop 1), data_ready=0 → data_valid=1, data_out=0x55, held; pulse data_ready → data_valid=0 next cycle.
- rx_in low for 20 clk then high → no data_valid, no error pulses, busy returns to 0 after the mid-start sample.
- Frame 0xA3 with stop bit 0 → framing_error single pulse, data_valid stays 0.
- Frames 0x11 then 0x22 with data_ready=0 → data_out=0x11, data_valid=1, one overrun_error pulse; then ready → data_valid=0.
- Back-to-back 0x3C, 0xC3 with data_ready=1, no idle gap → two single-cycle data_valid beats with values 0x3C, 0xC3 and no errors.
- reset_n low during bit 4 of a frame, then a clean 0x7E frame → outputs 0 during reset, then data_out=0x7E.
